// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target at a 7-bit address with a 2**REG_AW x 8 register file.
// The bus is oversampled with sys_clk; the block never stretches scl and drives sda
// only low (open-drain). It supports pointer writes, burst writes and burst reads,
// with the pointer auto-incrementing modulo the register-file depth.
// Optional build macro I2C_SLV_FILTER_EN: adds a 4-sample stability filter on the
// synchronized scl/sda lines (glitch rejection, +4 cycles of latency).
`timescale 1ns/1ps
module i2c_slave_regs #(
    parameter logic [6:0] SLV_ADDR = 7'h73,
    parameter int         REG_AW   = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic              scl,
    inout  wire               sda,
    input  logic              loc_we,
    input  logic [REG_AW-1:0] loc_addr,
    input  logic [7:0]        loc_wdata,
    output logic              wr_pulse,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int DEPTH = 1 << REG_AW;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    // ---------------------------------------------------------------
    // Bus synchronization and optional glitch filter
    // ---------------------------------------------------------------
    logic [1:0] scl_sync_reg;
    logic [1:0] sda_sync_reg;
    logic [1:0] line_raw;    // bit 0 = scl, bit 1 = sda
    logic [1:0] line_filt;

    // Two-flop synchronizers; idle bus level (high) is the reset value
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], scl};
            sda_sync_reg <= {sda_sync_reg[0], sda};
        end
    end

    assign line_raw = {sda_sync_reg[1], scl_sync_reg[1]};

`ifdef I2C_SLV_FILTER_EN
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            logic [1:0] cnt_reg;
            logic       val_reg;
            // Filtered level only follows the raw line after 4 consecutive differing samples
            always_ff @(posedge sys_clk or negedge sys_rstn) begin
                if (!sys_rstn) begin
                    cnt_reg <= 2'd0;
                    val_reg <= 1'b1;
                end else if (line_raw[gi] == val_reg) begin
                    cnt_reg <= 2'd0;
                end else if (cnt_reg == 2'd3) begin
                    val_reg <= line_raw[gi];
                    cnt_reg <= 2'd0;
                end else begin
                    cnt_reg <= cnt_reg + 2'd1;
                end
            end
            assign line_filt[gi] = val_reg;
        end
    endgenerate
`else
    assign line_filt = line_raw;
`endif

    logic scl_f;
    logic sda_f;
    logic scl_prev_reg;
    logic sda_prev_reg;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_f = line_filt[0];
    assign sda_f = line_filt[1];

    // Previous line levels for edge detection
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_f;
            sda_prev_reg <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_prev_reg;
    assign scl_fall  = ~scl_f & scl_prev_reg;
    assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
    assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;

    // ---------------------------------------------------------------
    // Protocol FSM and datapath
    // ---------------------------------------------------------------
    state_t            state_reg, state_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        rx_reg, rx_next;
    logic [7:0]        tx_reg, tx_next;
    logic [REG_AW-1:0] ptr_reg, ptr_next;
    logic              sda_oe_reg, sda_oe_next;
    logic              ack_ph_reg, ack_ph_next;       // 1 while our ACK bit is on the bus
    logic              load_pend_reg, load_pend_next; // next scl fall loads a read byte
    logic              rw_reg, rw_next;
    logic              busy_reg;
    logic              wr_pulse_reg;
    logic [REG_AW-1:0] wr_addr_reg;
    logic [7:0]        wr_data_reg;
    logic              i2c_we;
    logic [7:0]        rx_byte;
    logic [7:0]        rd_byte;
    logic [7:0]        reg_file [DEPTH];

    assign rx_byte = {rx_reg[6:0], sda_f};
    assign rd_byte = reg_file[ptr_reg];

    // FSM state and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            rx_reg        <= 8'h00;
            tx_reg        <= 8'h00;
            ptr_reg       <= '0;
            sda_oe_reg    <= 1'b0;
            ack_ph_reg    <= 1'b0;
            load_pend_reg <= 1'b0;
            rw_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            ptr_reg       <= ptr_next;
            sda_oe_reg    <= sda_oe_next;
            ack_ph_reg    <= ack_ph_next;
            load_pend_reg <= load_pend_next;
            rw_reg        <= rw_next;
        end
    end

    // Next-state logic: START/STOP override every state, bits shift on scl rise,
    // sda changes only on scl fall
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        ptr_next       = ptr_reg;
        sda_oe_next    = sda_oe_reg;
        ack_ph_next    = ack_ph_reg;
        load_pend_next = load_pend_reg;
        rw_next        = rw_reg;
        i2c_we         = 1'b0;

        if (stop_det) begin
            state_next     = IDLE;
            sda_oe_next    = 1'b0;
            ack_ph_next    = 1'b0;
            load_pend_next = 1'b0;
        end else if (start_det) begin
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            sda_oe_next    = 1'b0;
            ack_ph_next    = 1'b0;
            load_pend_next = 1'b0;
        end else begin
            case (state_reg)
                ADDR: begin
                    if (scl_rise) begin
                        rx_next      = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (rx_byte[7:1] == SLV_ADDR) begin
                                state_next  = ADDR_ACK;
                                rw_next     = rx_byte[0];
                                ack_ph_next = 1'b0;
                            end else begin
                                state_next = WAIT;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph_reg) begin
                            sda_oe_next = 1'b1;
                            ack_ph_next = 1'b1;
                        end else begin
                            ack_ph_next  = 1'b0;
                            bit_cnt_next = 3'd0;
                            if (rw_reg) begin
                                // The ACK-ending fall also presents the first read bit
                                state_next  = RDATA;
                                tx_next     = {rd_byte[6:0], 1'b0};
                                sda_oe_next = ~rd_byte[7];
                                ptr_next    = ptr_reg + 1'b1;
                            end else begin
                                state_next  = PTR;
                                sda_oe_next = 1'b0;
                            end
                        end
                    end
                end
                PTR, WDATA: begin
                    if (scl_rise) begin
                        rx_next      = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            ack_ph_next = 1'b0;
                            if (state_reg == PTR) begin
                                ptr_next   = rx_byte[REG_AW-1:0];
                                state_next = PTR_ACK;
                            end else begin
                                i2c_we     = 1'b1;
                                ptr_next   = ptr_reg + 1'b1;
                                state_next = WDATA_ACK;
                            end
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph_reg) begin
                            sda_oe_next = 1'b1;
                            ack_ph_next = 1'b1;
                        end else begin
                            sda_oe_next  = 1'b0;
                            ack_ph_next  = 1'b0;
                            bit_cnt_next = 3'd0;
                            state_next   = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (load_pend_reg) begin
                            tx_next        = {rd_byte[6:0], 1'b0};
                            sda_oe_next    = ~rd_byte[7];
                            ptr_next       = ptr_reg + 1'b1;
                            load_pend_next = 1'b0;
                        end else begin
                            tx_next     = {tx_reg[6:0], 1'b0};
                            sda_oe_next = ~tx_reg[7];
                        end
                    end
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_next = RDATA_ACK;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next = 1'b0;
                    end
                    if (scl_rise) begin
                        if (!sda_f) begin
                            state_next     = RDATA;
                            load_pend_next = 1'b1;
                            bit_cnt_next   = 3'd0;
                        end else begin
                            state_next = WAIT;
                        end
                    end
                end
                default: begin
                    // IDLE and WAIT: bus released, only START/STOP move us
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    // Register file: bus write has priority over the local port on the same entry
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_file[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i2c_we && (ptr_reg == REG_AW'(i))) begin
                    reg_file[i] <= rx_byte;
                end else if (loc_we && (loc_addr == REG_AW'(i))) begin
                    reg_file[i] <= loc_wdata;
                end
            end
        end
    end

    // Write strobe, its address/data, and the bus-busy flag
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            wr_pulse_reg <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= 8'h00;
            busy_reg     <= 1'b0;
        end else begin
            wr_pulse_reg <= i2c_we;
            if (i2c_we) begin
                wr_addr_reg <= ptr_reg;
                wr_data_reg <= rx_byte;
            end
            if (stop_det) begin
                busy_reg <= 1'b0;
            end else if (start_det) begin
                busy_reg <= 1'b1;
            end
        end
    end

    assign sda      = sda_oe_reg ? 1'b0 : 1'bz;
    assign wr_pulse = wr_pulse_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Testbench for i2c_slave_regs: a bit-level I2C master drives the bus; expected
// bus responses and register writes are queued at stimulus time and checked by
// independent monitor processes.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

    localparam int Q = 300;   // quarter of an scl bit period, in ns

    logic       clk = 1'b0;
    logic       rstn;
    logic       scl_m = 1'b1;
    logic       sda_low = 1'b0;
    logic       loc_we;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata;
    logic       wr_pulse;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda_bus;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #10 clk = ~clk;

    i2c_slave_regs dut (
        .sys_clk   (clk),
        .sys_rstn  (rstn),
        .scl       (scl_m),
        .sda       (sda_bus),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_wdata (loc_wdata),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    string exp_nm[$];
    int    exp_val[$];
    int    obs_val[$];
    int    exp_wa[$];
    int    exp_wd[$];

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end else begin
            $display("ok   %s value=%0h", nm, act);
        end
    endtask

    // Bus-response monitor: pairs each observation with the oldest expectation
    always @(negedge clk) begin
        if (obs_val.size() > 0) begin
            if (exp_val.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bus_unexpected actual=%0h required=none", obs_val.pop_front());
            end else begin
                chk(exp_nm.pop_front(), obs_val.pop_front(), exp_val.pop_front());
            end
        end
    end

    // Write-strobe monitor: every wr_pulse must match a queued write and last one cycle
    logic wr_prev = 1'b0;
    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            chk("wr_pulse_width", int'(wr_prev), 0);
            if (!wr_prev) begin
                if (exp_wa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected actual=%0h/%0h required=none", wr_addr, wr_data);
                end else begin
                    chk("wr_addr", int'(wr_addr), exp_wa.pop_front());
                    chk("wr_data", int'(wr_data), exp_wd.pop_front());
                end
            end
        end
        wr_prev = (wr_pulse === 1'b1);
    end

    task automatic expect_bus(input string nm, input int v);
        exp_nm.push_back(nm);
        exp_val.push_back(v);
    endtask

    task automatic bit_w(input logic b);
        sda_low = ~b; #Q; scl_m = 1'b1; #Q; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic bit_r(output logic b);
        sda_low = 1'b0; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; #Q; scl_m = 1'b1; #Q; sda_low = 1'b1; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; #Q; scl_m = 1'b1; #Q; sda_low = 1'b0; #Q; #Q;
    endtask

    task automatic byte_w(input logic [7:0] d, input int ack, input string nm);
        logic a;
        expect_bus(nm, ack);
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(a);
        obs_val.push_back(int'(a));
    endtask

    task automatic byte_r(input logic [7:0] req, input logic ack, input string nm);
        logic [7:0] d;
        logic       b;
        expect_bus(nm, int'(req));
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            d[i] = b;
        end
        obs_val.push_back(int'(d));
        bit_w(ack);
    endtask

    // Write pointer then repeated START and read nbytes (last one NACKed)
    task automatic read_regs(input logic [7:0] ptr, input logic [7:0] b0, input logic [7:0] b1,
                             input int two, input string nm);
        i2c_start();
        byte_w(8'hE6, 0, {nm, "_wack"});
        byte_w(ptr, 0, {nm, "_pack"});
        i2c_start();
        byte_w(8'hE7, 0, {nm, "_rack"});
        if (two != 0) begin
            byte_r(b0, 1'b0, {nm, "_b0"});
            byte_r(b1, 1'b1, {nm, "_b1"});
        end else begin
            byte_r(b0, 1'b1, {nm, "_b0"});
        end
        i2c_stop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int   n;
        rstn = 1'b0; loc_we = 1'b0; loc_addr = 4'h0; loc_wdata = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_sda", int'(sda_bus), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_pulse", int'(wr_pulse), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Burst write of two registers starting at 5
        i2c_start();
        byte_w(8'hE6, 0, "t1_addr_ack");
        byte_w(8'h05, 0, "t1_ptr_ack");
        expect_bus("t1_busy_mid", 1); obs_val.push_back(int'(busy));
        exp_wa.push_back(5); exp_wd.push_back(8'hA5);
        byte_w(8'hA5, 0, "t1_d0_ack");
        exp_wa.push_back(6); exp_wd.push_back(8'h3C);
        byte_w(8'h3C, 0, "t1_d1_ack");
        i2c_stop();
        expect_bus("t1_busy_after", 0); obs_val.push_back(int'(busy));
        read_regs(8'h05, 8'hA5, 8'h3C, 1, "t1_rb");

        // Local writes, then burst read across the pointer wrap, then WAIT
        @(negedge clk); loc_we = 1'b1; loc_addr = 4'hF; loc_wdata = 8'h11;
        @(negedge clk); loc_addr = 4'h0; loc_wdata = 8'h22;
        @(negedge clk); loc_we = 1'b0;
        i2c_start();
        byte_w(8'hE6, 0, "t2_wack");
        byte_w(8'h0F, 0, "t2_pack");
        i2c_start();
        byte_w(8'hE7, 0, "t2_rack");
        byte_r(8'h11, 1'b0, "t2_b0");
        byte_r(8'h22, 1'b1, "t2_b1_wrap");
        byte_r(8'hFF, 1'b1, "t2_wait_released");
        i2c_stop();

        // Foreign address: no ACK, no write
        i2c_start();
        byte_w(8'hA0, 1, "t3_addr_nack");
        byte_w(8'h12, 1, "t3_wait_nack");
        i2c_stop();

        // STOP inside a data byte aborts without writing
        i2c_start();
        byte_w(8'hE6, 0, "t4_wack");
        byte_w(8'h05, 0, "t4_pack");
        bit_w(1'b0); bit_w(1'b1); bit_w(1'b0);
        i2c_stop();
        expect_bus("t4_busy_after", 0); obs_val.push_back(int'(busy));
        read_regs(8'h05, 8'hA5, 8'h00, 0, "t4_rb");

        // Same-cycle bus write and local write to reg 3: bus wins
        i2c_start();
        byte_w(8'hE6, 0, "t5_wack");
        byte_w(8'h03, 0, "t5_pack");
        @(negedge clk); loc_we = 1'b1; loc_addr = 4'h3; loc_wdata = 8'h01;
        fork
            begin
                exp_wa.push_back(3); exp_wd.push_back(8'h77);
                byte_w(8'h77, 0, "t5_dack");
            end
            begin
                n = 0;
                while (wr_pulse !== 1'b1 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                loc_we = 1'b0;
                chk("t5_wr_seen", int'(wr_pulse === 1'b1), 1);
            end
        join
        i2c_stop();
        read_regs(8'h03, 8'h77, 8'h00, 0, "t5_rb");

        // 40 ns scl low glitch in the first address bit's high phase
        i2c_start();
`ifdef I2C_SLV_FILTER_EN
        expect_bus("t6_glitch_ack", 0);
`else
        expect_bus("t6_glitch_ack", 1);
`endif
        sda_low = 1'b0; #Q; scl_m = 1'b1; #100; scl_m = 1'b0; #40; scl_m = 1'b1; #160; #Q;
        scl_m = 1'b0; #Q;
        bit_w(1'b1); bit_w(1'b1); bit_w(1'b0); bit_w(1'b0); bit_w(1'b1); bit_w(1'b1); bit_w(1'b0);
        bit_r(a);
        obs_val.push_back(int'(a));
        i2c_stop();

        // Reset during our ACK: sda released at once, no response without a new START
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_w(n == -1 ? 1'b0 : ((8'hE6 >> i) & 1) != 0);
        sda_low = 1'b0; #Q; scl_m = 1'b1; #Q;
        expect_bus("t7_ack_driven", 0); obs_val.push_back(int'(sda_bus));
        rstn = 1'b0;
        #1;
        expect_bus("t7_rst_release", 1); obs_val.push_back(int'(sda_bus));
        expect_bus("t7_rst_busy", 0); obs_val.push_back(int'(busy));
        #(Q - 1); scl_m = 1'b0; #Q;
        rstn = 1'b1; #Q;
        byte_w(8'hE6, 1, "t7_no_start_nack");
        i2c_stop();
        read_regs(8'h05, 8'h00, 8'h00, 0, "t7_rb_cleared");

        repeat (20) @(negedge clk);
        chk("exp_bus_drained", exp_val.size(), 0);
        chk("exp_wr_drained", exp_wa.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
